// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART TX/RX pair: parity encodings,
// frame state encoding and the minimum legal baud divisor.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DIV = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Mode 2'b11 is an alias of "none".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..i_period-1 while running and flags the last
// clock of each period. The RX side reuses it with a half-period load.
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] r_cnt;

  assign o_bit_end = i_run && (r_cnt == i_period - DIV_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= o_bit_end ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: elaboration-time data width, per-frame
// baud divisor / parity / stop bits, gap-free back-to-back frames, RS-485 DE.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter bit DE_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_vld,
  input  logic [DATA_BITS-1:0] din,
  output logic                 din_rdy,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 dout,
  output logic                 de,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  uart_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_stop_sec, w_stop_sec_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DIV_W-1:0]     r_period;
  logic [1:0]           r_par;
  logic                 r_two_stop;
  logic                 r_dout, r_de, r_busy;

  logic                 w_bit_end, w_last_stop, w_accept, w_par_bit, w_dout_nxt;
  logic [DIV_W-1:0]     w_period_in;

  assign w_period_in = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign w_last_stop = (r_state == STOP) && w_bit_end && (!r_two_stop || r_stop_sec);
  assign w_accept    = din_vld && din_rdy;
  assign w_par_bit   = (^r_data) ^ (r_par == PAR_ODD);

  assign din_rdy = (r_state == IDLE) || w_last_stop;
  assign tx_done = w_last_stop;
  assign dout    = r_dout;
  assign de      = r_de;
  assign busy    = r_busy;

  uart_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept),
    .i_run    (r_state != IDLE),
    .i_period (r_period),
    .o_bit_end(w_bit_end)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_stop_sec_nxt = r_stop_sec;
    case (r_state)
      IDLE:   if (w_accept) w_state_nxt = START;
      START:  if (w_bit_end) begin
                w_state_nxt = DATA;
                w_idx_nxt   = '0;
              end
      DATA:   if (w_bit_end) begin
                if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                  w_state_nxt    = par_enabled(r_par) ? PARITY : STOP;
                  w_stop_sec_nxt = 1'b0;
                end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
                end
              end
      PARITY: if (w_bit_end) begin
                w_state_nxt    = STOP;
                w_stop_sec_nxt = 1'b0;
              end
      STOP:   if (w_last_stop) begin
                w_state_nxt = w_accept ? START : IDLE;
              end else if (w_bit_end) begin
                w_stop_sec_nxt = 1'b1;
              end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The line level is derived from the next state so dout is a plain flop.
  always_comb begin
    w_dout_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_dout_nxt = 1'b0;
      DATA:    w_dout_nxt = r_data[w_idx_nxt];
      PARITY:  w_dout_nxt = w_par_bit;
      default: w_dout_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_stop_sec <= 1'b0;
      r_dout     <= 1'b1;
      r_de       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_sec <= w_stop_sec_nxt;
      r_dout     <= w_dout_nxt;
      r_de       <= DE_EN && (w_state_nxt != IDLE);
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  // Frame settings are captured only on accept; mid-frame input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_period   <= DIV_W'(MIN_DIV);
      r_par      <= PAR_NONE;
      r_two_stop <= 1'b0;
    end else if (w_accept) begin
      r_data     <= din;
      r_period   <= w_period_in;
      r_par      <= par_enabled(parity_mode) ? parity_mode : PAR_NONE;
      r_two_stop <= two_stop;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: 8-bit instance plus 5-bit and 9-bit
// (DE disabled) instances, checked against a bit-position frame model.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0, din_vld5 = 1'b0, din_vld9 = 1'b0;
  logic [7:0]  din = '0;
  logic [4:0]  din5 = '0;
  logic [8:0]  din9 = '0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;

  logic din_rdy, dout, de, busy, tx_done;
  logic din_rdy5, dout5, de5, busy5, tx_done5;
  logic din_rdy9, dout9, de9, busy9, tx_done9;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .DIV_W(16), .DE_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .din_rdy(din_rdy),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .dout(dout), .de(de), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_cfg #(.DATA_BITS(5), .DIV_W(16), .DE_EN(1'b1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld5), .din(din5), .din_rdy(din_rdy5),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .dout(dout5), .de(de5), .busy(busy5), .tx_done(tx_done5)
  );

  uart_tx_cfg #(.DATA_BITS(9), .DIV_W(16), .DE_EN(1'b0)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld9), .din(din9), .din_rdy(din_rdy9),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .dout(dout9), .de(de9), .busy(busy9), .tx_done(tx_done9)
  );

  // ---------------- reference model ----------------
  function automatic int period_of(input int div);
    return (div < 2) ? 2 : div;
  endfunction

  function automatic bit has_par(input logic [1:0] par);
    return (par == 2'b01) || (par == 2'b10);
  endfunction

  function automatic int frame_len(input int nbits, input int div, input logic [1:0] par, input bit two);
    return period_of(div) * (1 + nbits + (has_par(par) ? 1 : 0) + (two ? 2 : 1));
  endfunction

  // Line level t clocks after the first start-bit clock; 1 beyond the frame.
  function automatic logic model_bit(input logic [8:0] data, input int nbits,
                                     input logic [1:0] par, input int div, input int t);
    int b;
    int ones;
    b = t / period_of(div);
    ones = 0;
    if (b == 0) return 1'b0;
    b = b - 1;
    if (b < nbits) return data[b];
    b = b - nbits;
    if (has_par(par) && b == 0) begin
      for (int i = 0; i < nbits; i++) ones += int'(data[i]);
      return ((ones % 2) == 1) ^ (par == 2'b10);
    end
    return 1'b1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_total++;
    if ({dout, de, busy, tx_done} !== 4'b1000) $display("FAIL reset_outputs: dout,de,busy,tx_done=%b required 1000", {dout, de, busy, tx_done});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({din_rdy, din_rdy5, din_rdy9} !== 3'b111) $display("FAIL reset_rdy: din_rdy(8,5,9)=%b required 111", {din_rdy, din_rdy5, din_rdy9});
    else n_pass++;
    n_total++;
    if ({dout, dout5, dout9, de, de5, de9, busy} !== 7'b1110000) $display("FAIL reset_idle_line: got %b required 1110000", {dout, dout5, dout9, de, de5, de9, busy});
    else n_pass++;
  endtask

  task automatic run_frame(input logic [7:0] data, input int div, input logic [1:0] par,
                           input bit two, input bit noisy);
    int len, guard, e_wave, e_de, e_busy, e_done, e_rdy, first_bad;
    logic want;
    len = frame_len(8, div, par, two);
    guard = 0;
    @(negedge clk);
    while (din_rdy !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    n_total++;
    if (guard >= 500) begin
      $display("FAIL rdy_timeout: din_rdy=%b required 1 within 500 clocks", din_rdy);
      return;
    end
    n_pass++;
    din = data; baud_div = 16'(div); parity_mode = par; two_stop = two; din_vld = 1'b1;
    @(posedge clk);
    #1 din_vld = 1'b0;
    e_wave = 0; e_de = 0; e_busy = 0; e_done = 0; e_rdy = 0; first_bad = -1;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      want = model_bit({1'b0, data}, 8, par, div, t);
      if (dout !== want) begin
        e_wave++;
        if (first_bad < 0) first_bad = t;
      end
      if (de !== 1'b1) e_de++;
      if (busy !== 1'b1) e_busy++;
      if (tx_done !== (t == len - 1)) e_done++;
      if (din_rdy !== (t == len - 1)) e_rdy++;
      if (noisy) begin
        din         = 8'($urandom);
        baud_div    = 16'($urandom_range(0, 12));
        parity_mode = 2'($urandom);
        two_stop    = 1'($urandom);
        din_vld     = (t < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    n_total++;
    if (e_wave != 0) $display("FAIL frame_wave data=%h div=%0d par=%0d two=%0d: %0d bad clocks, first at %0d, required 0", data, div, par, two, e_wave, first_bad);
    else n_pass++;
    n_total++;
    if (e_de != 0 || e_busy != 0) $display("FAIL frame_de_busy: de low %0d clocks, busy low %0d clocks, required 0/0", e_de, e_busy);
    else n_pass++;
    n_total++;
    if (e_done != 0) $display("FAIL frame_tx_done: %0d clocks wrong, required pulse only at clock %0d", e_done, len - 1);
    else n_pass++;
    n_total++;
    if (e_rdy != 0) $display("FAIL frame_din_rdy: %0d clocks wrong, required high only at clock %0d", e_rdy, len - 1);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({dout, de, busy, tx_done, din_rdy} !== 5'b10001) $display("FAIL frame_idle_after: dout,de,busy,tx_done,din_rdy=%b required 10001", {dout, de, busy, tx_done, din_rdy});
    else n_pass++;
  endtask

  task automatic test_basic;
    run_frame(8'hA5, 4, 2'b00, 1'b0, 1'b0);
    run_frame(8'h3C, 5, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic test_parity;
    run_frame(8'hA5, 4, 2'b01, 1'b0, 1'b0);
    run_frame(8'hA5, 4, 2'b10, 1'b0, 1'b0);
    run_frame(8'hA5, 4, 2'b10, 1'b1, 1'b0);
    run_frame(8'h07, 3, 2'b01, 1'b1, 1'b0);
  endtask

  task automatic test_divisor;
    run_frame(8'h96, 0, 2'b00, 1'b0, 1'b0);
    run_frame(8'h69, 1, 2'b01, 1'b0, 1'b0);
    run_frame(8'hC3, 4, 2'b10, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      run_frame(8'($urandom), int'($urandom_range(0, 7)), 2'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic run_b2b(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input int div, input logic [1:0] par, input bit two);
    logic [7:0] words [3];
    int len, total, k, n, guard, e_wave, e_de, e_done, e_rdy, n_done, first_bad;
    logic acc, want;
    bit started;
    words = '{w0, w1, w2};
    len = frame_len(8, div, par, two);
    total = 3 * len;
    k = 0; n = 0; guard = 0; started = 1'b0;
    e_wave = 0; e_de = 0; e_done = 0; e_rdy = 0; n_done = 0; first_bad = -1;
    @(negedge clk);
    din = w0; baud_div = 16'(div); parity_mode = par; two_stop = two; din_vld = 1'b1;
    while (n < total && guard < total + 50) begin
      guard++;
      if (started) begin
        want = model_bit({1'b0, words[n / len]}, 8, par, div, n % len);
        if (dout !== want) begin
          e_wave++;
          if (first_bad < 0) first_bad = n;
        end
        if (de !== 1'b1) e_de++;
        if (tx_done === 1'b1) n_done++;
        if (tx_done !== ((n % len) == len - 1)) e_done++;
        if (din_rdy !== ((n % len) == len - 1)) e_rdy++;
        n++;
      end
      acc = din_vld && din_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        started = 1'b1;
        k++;
        if (k < 3) din = words[k];
        else din_vld = 1'b0;
      end
      @(negedge clk);
    end
    din_vld = 1'b0;
    n_total++;
    if (n != total || k != 3) $display("FAIL b2b_progress: sampled %0d clocks, %0d accepts, required %0d clocks, 3 accepts", n, k, total);
    else n_pass++;
    n_total++;
    if (e_wave != 0) $display("FAIL b2b_wave: %0d bad clocks, first at %0d, required 0", e_wave, first_bad);
    else n_pass++;
    n_total++;
    if (e_de != 0) $display("FAIL b2b_de: de low %0d of %0d clocks, required 0", e_de, total);
    else n_pass++;
    n_total++;
    if (e_done != 0 || n_done != 3) $display("FAIL b2b_tx_done: %0d pulses, %0d misplaced, required 3 pulses, 0 misplaced", n_done, e_done);
    else n_pass++;
    n_total++;
    if (e_rdy != 0) $display("FAIL b2b_din_rdy: %0d clocks wrong, required 0", e_rdy);
    else n_pass++;
    n_total++;
    if ({dout, de, busy} !== 3'b100) $display("FAIL b2b_idle_after: dout,de,busy=%b required 100", {dout, de, busy});
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    run_b2b(8'h01, 8'h02, 8'h03, 4, 2'b00, 1'b0);
    run_b2b(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), 2'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    din = 8'h5A; baud_div = 16'd4; parity_mode = 2'b01; two_stop = 1'b0; din_vld = 1'b1;
    @(posedge clk);
    #1 din_vld = 1'b0;
    repeat (18) @(negedge clk);
    n_total++;
    if ({busy, de, dout} !== {2'b11, 1'b1}) $display("FAIL midframe_before: busy,de,dout=%b required 111 (data bit 3 of 5A)", {busy, de, dout});
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({dout, de, busy, tx_done} !== 4'b1000) $display("FAIL midframe_abort: dout,de,busy,tx_done=%b required 1000", {dout, de, busy, tx_done});
    else n_pass++;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({din_rdy, dout, de, busy} !== 4'b1100) $display("FAIL midframe_release: din_rdy,dout,de,busy=%b required 1100", {din_rdy, dout, de, busy});
    else n_pass++;
    run_frame(8'($urandom), 4, 2'b10, 1'b1, 1'b0);
  endtask

  task automatic test_widths;
    logic [4:0] d5;
    logic [8:0] d9;
    logic [1:0] par;
    bit two;
    int div, len5, len9, e5, e9, ed5, ed9, ede;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        d5 = 5'h1F; d9 = 9'h1FF; par = 2'b10; two = 1'b0; div = 3;
      end else begin
        d5 = 5'($urandom); d9 = 9'($urandom); par = 2'($urandom); two = 1'($urandom);
        div = int'($urandom_range(0, 5));
      end
      len5 = frame_len(5, div, par, two);
      len9 = frame_len(9, div, par, two);
      e5 = 0; e9 = 0; ed5 = 0; ed9 = 0; ede = 0;
      @(negedge clk);
      n_total++;
      if ({din_rdy5, din_rdy9} !== 2'b11) $display("FAIL width_rdy: din_rdy5,din_rdy9=%b required 11", {din_rdy5, din_rdy9});
      else n_pass++;
      din5 = d5; din9 = d9; baud_div = 16'(div); parity_mode = par; two_stop = two;
      din_vld5 = 1'b1; din_vld9 = 1'b1;
      @(posedge clk);
      #1 begin din_vld5 = 1'b0; din_vld9 = 1'b0; end
      for (int t = 0; t < len9; t++) begin
        @(negedge clk);
        if (dout5 !== model_bit({4'b0, d5}, 5, par, div, t)) e5++;
        if (dout9 !== model_bit(d9, 9, par, div, t)) e9++;
        if (tx_done5 !== (t == len5 - 1)) ed5++;
        if (tx_done9 !== (t == len9 - 1)) ed9++;
        if (de5 !== (t < len5) || de9 !== 1'b0) ede++;
      end
      n_total++;
      if (e5 != 0) $display("FAIL width5_wave d=%h par=%0d div=%0d: %0d bad clocks, required 0", d5, par, div, e5);
      else n_pass++;
      n_total++;
      if (e9 != 0) $display("FAIL width9_wave d=%h par=%0d div=%0d: %0d bad clocks, required 0", d9, par, div, e9);
      else n_pass++;
      n_total++;
      if (ed5 != 0 || ed9 != 0) $display("FAIL width_tx_done: misplaced 5-bit %0d, 9-bit %0d, required 0/0", ed5, ed9);
      else n_pass++;
      n_total++;
      if (ede != 0) $display("FAIL width_de: %0d clocks wrong (de5 over frame, de9 tied low), required 0", ede);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_divisor;
    test_random;
    test_back_to_back;
    test_reset_mid_frame;
    test_widths;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
